// File: rtl/count_updown_param.sv
// Parametrised up/down counter with prescaler, parallel load, wrap/saturate
// bounds, a registered terminal-count pulse and combinational zero/at_max flags.
module count_updown_param #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MODULUS  = 16,
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             lever,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             zero,
  output logic             at_max
);

  localparam int unsigned    PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             tc_q, tc_d;
  logic             tick;

  assign tick = en && (pre_q == PRE_LAST);

  // Next-state: load beats counting; tc is a one-cycle pulse, cleared by default
  always_comb begin
    q_d   = q_q;
    pre_d = pre_q;
    tc_d  = 1'b0;
    if (load) begin
      q_d   = (d > MAX_VAL) ? MAX_VAL : d;
      pre_d = '0;
    end else if (en) begin
      pre_d = tick ? '0 : pre_q + PW'(1);
      if (tick) begin
        if (lever) begin
          if (q_q == MAX_VAL) begin
            tc_d = 1'b1;
            q_d  = (SATURATE != 0) ? q_q : '0;
          end else begin
            q_d  = q_q + WIDTH'(1);
          end
        end else begin
          if (q_q == '0) begin
            tc_d = 1'b1;
            q_d  = (SATURATE != 0) ? q_q : MAX_VAL;
          end else begin
            q_d  = q_q - WIDTH'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q   <= '0;
      pre_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      q_q   <= q_d;
      pre_q <= pre_d;
      tc_q  <= tc_d;
    end
  end

  assign q      = q_q;
  assign tc     = tc_q;
  assign zero   = (q_q == '0);
  assign at_max = (q_q == MAX_VAL);

endmodule

// File: tb/tb_count_updown_param.sv
// Bench for count_updown_param: five configurations share one stimulus stream,
// checked by hand-written vectors and an arithmetic reference model.
module tb_count_updown_param;

  localparam int N = 5;
  localparam int PM [N] = '{16, 10, 16, 16, 12};
  localparam int PP [N] = '{1, 1, 1, 4, 3};
  localparam int PS [N] = '{0, 0, 1, 0, 1};
  localparam int PWD[N] = '{4, 4, 4, 4, 5};

  logic       clk;
  logic       rst, en, lever, load;
  logic [4:0] d_in;
  logic [3:0] q0, q1, q2, q3;
  logic [4:0] q4;
  logic [4:0] tcv, zv, mv;
  logic [4:0] aq [N];

  int checks = 0;
  int errors = 0;
  int mq[N], mcnt[N], mtc[N];
  bit chk_on = 0;

  count_updown_param u0 (.clk(clk), .reset(rst), .en(en), .lever(lever), .load(load),
    .d(d_in[3:0]), .q(q0), .tc(tcv[0]), .zero(zv[0]), .at_max(mv[0]));
  count_updown_param #(.MODULUS(10)) u1 (.clk(clk), .reset(rst), .en(en), .lever(lever),
    .load(load), .d(d_in[3:0]), .q(q1), .tc(tcv[1]), .zero(zv[1]), .at_max(mv[1]));
  count_updown_param #(.SATURATE(1)) u2 (.clk(clk), .reset(rst), .en(en), .lever(lever),
    .load(load), .d(d_in[3:0]), .q(q2), .tc(tcv[2]), .zero(zv[2]), .at_max(mv[2]));
  count_updown_param #(.PRESCALE(4)) u3 (.clk(clk), .reset(rst), .en(en), .lever(lever),
    .load(load), .d(d_in[3:0]), .q(q3), .tc(tcv[3]), .zero(zv[3]), .at_max(mv[3]));
  count_updown_param #(.WIDTH(5), .MODULUS(12), .PRESCALE(3), .SATURATE(1)) u4 (
    .clk(clk), .reset(rst), .en(en), .lever(lever), .load(load), .d(d_in),
    .q(q4), .tc(tcv[4]), .zero(zv[4]), .at_max(mv[4]));

  assign aq[0] = 5'(q0);
  assign aq[1] = 5'(q1);
  assign aq[2] = 5'(q2);
  assign aq[3] = 5'(q3);
  assign aq[4] = q4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst, en, lever, load;
    logic [4:0] d;
    int         q0, tc0, q1, tc1;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Reference: count enabled clocks since the last load/reset; every PRESCALE-th
  // one is a tick that moves q by +/-1, folding or clamping at the range ends.
  task automatic model_step();
    for (int i = 0; i < N; i++) begin
      int dv, nxt;
      dv = int'(d_in) & ((1 << PWD[i]) - 1);
      if (rst) begin
        mq[i] = 0; mcnt[i] = 0; mtc[i] = 0;
      end else if (load) begin
        mq[i] = (dv > PM[i] - 1) ? PM[i] - 1 : dv; mcnt[i] = 0; mtc[i] = 0;
      end else begin
        mtc[i] = 0;
        if (en) begin
          mcnt[i]++;
          if (mcnt[i] % PP[i] == 0) begin
            nxt = mq[i] + (lever ? 1 : -1);
            if (nxt < 0 || nxt >= PM[i]) begin
              mtc[i] = 1;
              if (PS[i] == 0) mq[i] = (nxt + PM[i]) % PM[i];
            end else begin
              mq[i] = nxt;
            end
          end
        end
      end
    end
    if (rst) chk_on = 1;
  endtask

  task automatic compare_all();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("model u%0d q", i), int'(aq[i]), mq[i]);
      chk($sformatf("model u%0d tc", i), int'(tcv[i]), mtc[i]);
      chk($sformatf("model u%0d zero", i), int'(zv[i]), int'(mq[i] == 0));
      chk($sformatf("model u%0d at_max", i), int'(mv[i]), int'(mq[i] == PM[i] - 1));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    if (chk_on) compare_all();
  endtask

  task automatic add(input logic r, input logic e, input logic lv, input logic ld,
                     input int dd, input int eq0, input int et0, input int eq1, input int et1);
    vec_t v;
    v.rst = r; v.en = e; v.lever = lv; v.load = ld; v.d = 5'(dd);
    v.q0 = eq0; v.tc0 = et0; v.q1 = eq1; v.tc1 = et1;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic r, input logic e, input logic lv, input logic ld, input int dd);
    rst = r; en = e; lever = lv; load = ld; d_in = 5'(dd);
  endtask

  initial begin
    // Vectors: u0 is the default 0..15 wrap counter, u1 the modulus-10 one
    add(1, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 20; k++)
      add(0, 1, 1, 0, 0, k % 16, int'(k == 16), k % 10, int'(k == 10 || k == 20));
    add(0, 0, 1, 1, 12, 12, 0, 9, 0);
    add(0, 1, 1, 1, 5, 5, 0, 5, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 15, 1, 9, 1);
    add(0, 1, 0, 0, 0, 14, 0, 8, 0);
    add(0, 1, 0, 0, 0, 13, 0, 7, 0);
    add(0, 1, 1, 1, 7, 7, 0, 7, 0);
    add(1, 1, 1, 1, 3, 0, 0, 0, 0);
    add(0, 1, 1, 1, 15, 15, 0, 9, 0);
    add(0, 1, 1, 0, 0, 0, 1, 0, 1);
    add(1, 1, 1, 0, 0, 0, 0, 0, 0);

    drive(1, 0, 1, 0, 0);
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].lever, tbl[i].load, int'(tbl[i].d));
      cyc();
      chk($sformatf("vec%0d u0 q", i), int'(q0), tbl[i].q0);
      chk($sformatf("vec%0d u0 tc", i), int'(tcv[0]), tbl[i].tc0);
      chk($sformatf("vec%0d u1 q", i), int'(q1), tbl[i].q1);
      chk($sformatf("vec%0d u1 tc", i), int'(tcv[1]), tbl[i].tc1);
    end

    // Saturating instance held at the top: tc re-pulses on each boundary tick
    begin
      int sq[5] = '{14, 15, 15, 15, 15};
      int st[5] = '{0, 0, 1, 1, 1};
      drive(0, 1, 1, 1, 13);
      cyc();
      chk("sat load", int'(q2), 13);
      drive(0, 1, 1, 0, 0);
      for (int i = 0; i < 5; i++) begin
        cyc();
        chk($sformatf("sat up%0d q", i), int'(q2), sq[i]);
        chk($sformatf("sat up%0d tc", i), int'(tcv[2]), st[i]);
      end
      drive(0, 1, 0, 0, 0);
      cyc();
      chk("sat down q", int'(q2), 14);
      chk("sat down tc", int'(tcv[2]), 0);
    end

    // Prescale-4 instance: a 3-clock en gap delays the next step by 3 clocks
    drive(1, 0, 1, 0, 0);
    cyc();
    drive(0, 1, 1, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk($sformatf("pre clk%0d q", i), int'(q3), (i == 4) ? 1 : 0);
    end
    cyc(); cyc();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("pre gap%0d q", i), int'(q3), 1);
    end
    en = 1'b1;
    cyc();
    chk("pre late q", int'(q3), 1);
    cyc();
    chk("pre step q", int'(q3), 2);
    chk("pre step at_max", int'(mv[3]), 0);

    // Randomized traffic against the reference model
    drive(1, 0, 1, 0, 0);
    cyc();
    for (int n = 0; n < 3000; n++) begin
      rst   = ($urandom_range(0, 63) == 0);
      load  = ($urandom_range(0, 15) == 0);
      en    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) lever = ~lever;
      d_in  = 5'($urandom_range(0, 31));
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
